// File: rtl/isq_issue_arb.sv
// Two-requester round-robin issue arbiter feeding one registered output slot.
// Flush kills a held entry younger than the flushing instruction.
module isq_issue_arb #(
    parameter int DATA_WIDTH     = 248,
    parameter int INSTR_ID_WIDTH = 7
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [DATA_WIDTH-1:0]     req0_data,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [DATA_WIDTH-1:0]     req1_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_src,
    input  logic                      flush_valid,
    input  logic [INSTR_ID_WIDTH-1:0] flush_id,
    output logic [15:0]               grant_cnt0,
    output logic [15:0]               grant_cnt1
);

    localparam int IW = INSTR_ID_WIDTH;

    logic                  held_q, held_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  src_q, src_d;
    logic                  rr_q, rr_d;
    logic [15:0]           cnt0_q, cnt0_d;
    logic [15:0]           cnt1_q, cnt1_d;

    logic          gnt0, gnt1;
    logic          fire0, fire1;
    logic          kill, out_fire, can_accept;
    logic [IW-1:0] held_id;

    // Wrap bit flips the sense of the magnitude compare.
    function automatic logic younger(input logic [IW-1:0] id,
                                     input logic [IW-1:0] f);
        return (id[IW-1] ^ f[IW-1]) ^ (id[IW-2:0] > f[IW-2:0]);
    endfunction

    assign held_id = data_q[DATA_WIDTH-1 -: INSTR_ID_WIDTH];

    always_comb begin
        gnt0       = req0_valid && (!req1_valid || !rr_q);
        gnt1       = req1_valid && (!req0_valid || rr_q);
        kill       = flush_valid && younger(held_id, flush_id);
        out_valid  = reset_n && held_q && !kill;
        out_fire   = out_valid && out_ready;
        can_accept = !held_q || out_fire;
        req0_ready = reset_n && gnt0 && can_accept && !flush_valid;
        req1_ready = reset_n && gnt1 && can_accept && !flush_valid;
        fire0      = req0_valid && req0_ready;
        fire1      = req1_valid && req1_ready;
    end

    always_comb begin
        held_d = held_q;
        data_d = data_q;
        src_d  = src_q;
        rr_d   = rr_q;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (out_fire || kill) begin
            held_d = 1'b0;
        end
        if (fire0) begin
            held_d = 1'b1;
            data_d = req0_data;
            src_d  = 1'b0;
            rr_d   = 1'b1;
            cnt0_d = (cnt0_q == 16'hFFFF) ? cnt0_q : cnt0_q + 16'd1;
        end
        if (fire1) begin
            held_d = 1'b1;
            data_d = req1_data;
            src_d  = 1'b1;
            rr_d   = 1'b0;
            cnt1_d = (cnt1_q == 16'hFFFF) ? cnt1_q : cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            held_q <= 1'b0;
            data_q <= '0;
            src_q  <= 1'b0;
            rr_q   <= 1'b0;
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            held_q <= held_d;
            data_q <= data_d;
            src_q  <= src_d;
            rr_q   <= rr_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign out_data   = data_q;
    assign out_src    = src_q;
    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_isq_issue_arb.sv
// Bench for isq_issue_arb: directed scenarios with a FIFO scoreboard
// of accepted entries checked against the output slot.
module tb_isq_issue_arb;

    localparam int DW = 248;
    localparam int IW = 7;

    logic          clock;
    logic          reset_n;
    logic          req0_valid, req0_ready;
    logic [DW-1:0] req0_data;
    logic          req1_valid, req1_ready;
    logic [DW-1:0] req1_data;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic          out_src;
    logic          flush_valid;
    logic [IW-1:0] flush_id;
    logic [15:0]   grant_cnt0, grant_cnt1;

    isq_issue_arb #(.DATA_WIDTH(DW), .INSTR_ID_WIDTH(IW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .flush_valid(flush_valid),
        .flush_id   (flush_id),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [DW-1:0] d;
        logic          s;
    } ent_t;

    ent_t sbq[$];
    int   nvec;
    int   nfail;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [IW-1:0] id);
        logic [DW-1:0] d;
        d = '0;
        for (int j = 0; j < 7; j++) d[j*32 +: 32] = $urandom;
        d[DW-1:224] = 24'($urandom);
        d[DW-1 -: IW] = id;
        return d;
    endfunction

    task automatic sb();
        ent_t e;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("sb_data", out_data, e.d);
                chk("sb_src", out_src, e.s);
            end
        end
        if (req0_valid && req0_ready) begin
            e.d = req0_data;
            e.s = 1'b0;
            sbq.push_back(e);
        end
        if (req1_valid && req1_ready) begin
            e.d = req1_data;
            e.s = 1'b1;
            sbq.push_back(e);
        end
    endtask

    task automatic drop(input string tag);
        chk(tag, sbq.size(), 1);
        if (sbq.size() > 0) void'(sbq.pop_front());
    endtask

    task automatic nx();
        @(negedge clock);
    endtask

    task automatic edge_();
        #1;
        sb();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [DW-1:0] d1, d2;
        nvec  = 0;
        nfail = 0;

        // reset with both requesters asserting
        reset_n     = 1'b0;
        req0_valid  = 1'b1;
        req1_valid  = 1'b1;
        req0_data   = mk(7'd1);
        req1_data   = mk(7'd2);
        out_ready   = 1'b1;
        flush_valid = 1'b0;
        flush_id    = '0;
        nx();
        chk("rst_ov", out_valid, 0);
        chk("rst_r0", req0_ready, 0);
        chk("rst_r1", req1_ready, 0);
        chk("rst_data", out_data, 0);
        chk("rst_src", out_src, 0);
        chk("rst_cnt0", grant_cnt0, 0);
        chk("rst_cnt1", grant_cnt1, 0);
        edge_();

        // continuous tie: strict alternation starting at req0
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_data = mk(7'(i));
            req1_data = mk(7'(i + 8));
            nx();
            chk("rr_g0", req0_ready, (i % 2) == 0);
            chk("rr_g1", req1_ready, (i % 2) == 1);
            chk("rr_ov", out_valid, i > 0);
            if (i > 0) chk("rr_src", out_src, (i - 1) % 2);
            edge_();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        nx();
        chk("rr_drain_ov", out_valid, 1);
        chk("rr_cnt0", grant_cnt0, 3);
        chk("rr_cnt1", grant_cnt1, 3);
        edge_();

        // backpressure on a single requester
        d1 = mk(7'd20);
        d2 = mk(7'd21);
        req1_valid = 1'b1;
        req1_data  = d1;
        out_ready  = 1'b0;
        nx();
        chk("bp_r1_first", req1_ready, 1);
        chk("bp_ov_first", out_valid, 0);
        edge_();
        req1_data = d2;
        for (int k = 0; k < 2; k++) begin
            nx();
            chk("bp_ov", out_valid, 1);
            chk("bp_r1_held", req1_ready, 0);
            chk("bp_stable", out_data, d1);
            chk("bp_src", out_src, 1);
            edge_();
        end
        out_ready = 1'b1;
        nx();
        chk("bp_b2b_r1", req1_ready, 1);
        chk("bp_b2b_data", out_data, d1);
        edge_();
        req1_valid = 1'b0;
        nx();
        chk("bp_next_data", out_data, d2);
        chk("bp_next_ov", out_valid, 1);
        edge_();

        // flush kills a younger held entry
        req0_valid = 1'b1;
        req0_data  = mk(7'b0_000101);
        out_ready  = 1'b0;
        nx();
        chk("fl_load", req0_ready, 1);
        edge_();
        req0_data   = mk(7'd30);
        req1_valid  = 1'b1;
        req1_data   = mk(7'd31);
        flush_valid = 1'b1;
        flush_id    = 7'b0_000011;
        out_ready   = 1'b1;
        nx();
        chk("fl_ov", out_valid, 0);
        chk("fl_r0", req0_ready, 0);
        chk("fl_r1", req1_ready, 0);
        edge_();
        drop("fl_drop");
        flush_valid = 1'b0;
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        nx();
        chk("fl_cleared", out_valid, 0);
        chk("fl_cnt0", grant_cnt0, 4);
        chk("fl_cnt1", grant_cnt1, 5);
        edge_();

        // wrap-bit younger is killed
        req0_valid = 1'b1;
        req0_data  = mk(7'b1_000001);
        out_ready  = 1'b0;
        nx();
        edge_();
        req0_valid  = 1'b0;
        flush_valid = 1'b1;
        flush_id    = 7'b0_111110;
        out_ready   = 1'b1;
        nx();
        chk("wr_ov", out_valid, 0);
        edge_();
        drop("wr_drop");
        flush_valid = 1'b0;
        nx();
        chk("wr_cleared", out_valid, 0);
        edge_();

        // equal id survives flush and fires
        req0_valid = 1'b1;
        req0_data  = mk(7'b0_001000);
        out_ready  = 1'b0;
        nx();
        edge_();
        req0_valid  = 1'b0;
        flush_valid = 1'b1;
        flush_id    = 7'b0_001000;
        out_ready   = 1'b1;
        nx();
        chk("eq_ov", out_valid, 1);
        chk("eq_r0", req0_ready, 0);
        edge_();
        flush_valid = 1'b0;
        nx();
        chk("eq_gone", out_valid, 0);
        chk("eq_cnt0", grant_cnt0, 6);
        edge_();

        // reset while holding with both requesters valid
        req0_valid = 1'b1;
        req0_data  = mk(7'd40);
        out_ready  = 1'b0;
        nx();
        edge_();
        req1_valid = 1'b1;
        req1_data  = mk(7'd41);
        req0_data  = mk(7'd42);
        reset_n    = 1'b0;
        out_ready  = 1'b1;
        nx();
        chk("mr_ov", out_valid, 0);
        chk("mr_r0", req0_ready, 0);
        chk("mr_r1", req1_ready, 0);
        edge_();
        drop("mr_drop");
        reset_n = 1'b1;
        nx();
        chk("mr_data", out_data, 0);
        chk("mr_src", out_src, 0);
        chk("mr_ov_after", out_valid, 0);
        chk("mr_cnt0", grant_cnt0, 0);
        chk("mr_cnt1", grant_cnt1, 0);
        chk("mr_tie_r0", req0_ready, 1);
        chk("mr_tie_r1", req1_ready, 0);
        edge_();

        // counter saturation on req0
        req1_valid = 1'b0;
        for (int i = 0; i < 65533; i++) begin
            req0_data = mk(7'(i));
            nx();
            edge_();
        end
        nx();
        chk("sat_fffe", grant_cnt0, 16'hFFFE);
        edge_();
        nx();
        chk("sat_ffff", grant_cnt0, 16'hFFFF);
        edge_();
        nx();
        chk("sat_hold", grant_cnt0, 16'hFFFF);
        req0_valid = 1'b0;
        edge_();
        nx();
        chk("end_ov", out_valid, 0);
        chk("end_cnt1", grant_cnt1, 0);
        chk("end_sb_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/isq_issue_arb.md
ISQ_ISSUE_ARB -- requirements
Module: isq_issue_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 248, width of one issue-queue entry.
REQ-002 SHALL have parameter INSTR_ID_WIDTH, default 7, instr id width; MSB is the wrap bit, id sits at data[DATA_WIDTH-1 -: INSTR_ID_WIDTH].
REQ-003 clock  input  1  sole clock, rising edge.
REQ-004 reset_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 req0_valid  input  1  issue queue 0 holds a ready entry.
REQ-006 req0_ready  output  1  arbiter accepts req0_data this cycle.
REQ-007 req0_data  input  DATA_WIDTH  issue queue 0 entry.
REQ-008 req1_valid / req1_ready / req1_data: same as REQ-005..007 for issue queue 1.
REQ-009 out_valid  output  1  registered entry presented to the shared FU/PRF read stage.
REQ-010 out_ready  input  1  downstream accepts out_data.
REQ-011 out_data  output  DATA_WIDTH  registered granted entry.
REQ-012 out_src  output  1  requester index of out_data.
REQ-013 flush_valid  input  1  rollback in progress this cycle.
REQ-014 flush_id  input  INSTR_ID_WIDTH  id of flushing instruction.
REQ-015 grant_cnt0 / grant_cnt1  output  16 each  saturating accepted-entry counters per requester.

Function
REQ-016 Output stage SHALL be one register slot (held_valid, out_data, out_src); can_accept = !held_valid || (out_valid && out_ready).
REQ-017 Grant SHALL be combinational: only one requester valid -> that one; both valid -> requester equal to rr_ptr; none -> no grant.
REQ-018 reqK_ready SHALL be high iff grantK && can_accept && !flush_valid; at most one ready high per cycle.
REQ-019 reqK_ready SHALL NOT depend on reqK_valid of the same requester except through grant (no ready-to-valid loop on the winner's own path beyond REQ-017).
REQ-020 On reqK fire, next cycle held_valid=1, out_data=reqK_data, out_src=K; latency request-fire to out_valid is exactly 1 cycle.
REQ-021 Downstream fire with no new accept SHALL clear held_valid; simultaneous downstream fire and accept SHALL load new entry (back-to-back, 1 entry/cycle throughput).
REQ-022 Held entry with out_ready=0 SHALL keep out_data/out_src stable.
REQ-023 rr_ptr (1 bit) SHALL update to !K on every reqK fire, otherwise hold; a requester losing a tie wins the next tie.
REQ-024 Younger-than test: younger(id) = (id[MSB] ^ flush_id[MSB]) ^ (id[MSB-1:0] > flush_id[MSB-1:0]); equal ids are not younger.
REQ-025 During flush_valid: no accept; if held entry younger, out_valid SHALL be forced 0 combinationally that cycle and held_valid cleared next cycle; if not younger, entry remains and may fire normally.
REQ-026 out_valid = held_valid && !(flush_valid && younger(held id)).
REQ-027 grant_cntK SHALL increment by 1 on each reqK fire, saturating at 16'hFFFF; no wrap.
REQ-028 Flush SHALL NOT modify rr_ptr or grant counters.

Reset
REQ-029 With reset_n=0 at a rising edge: held_valid=0, out_data=0, out_src=0, rr_ptr=0, grant_cnt0=grant_cnt1=0.
REQ-030 During reset req0_ready=req1_ready=0 and out_valid=0; reset mid-transfer SHALL drop held entry without downstream fire.
REQ-031 First cycle after reset_n rises SHALL allow accepts.

Verification
REQ-032 Both requesters valid continuously, out_ready=1, 6 cycles -> grants 0,1,0,1,0,1; out_valid every cycle from cycle 2; grant_cnt0=grant_cnt1=3.
REQ-033 Only req1 valid, out_ready=0 after first accept -> req1_ready=0 while held; out_data stable; on out_ready=1 one fire then next accept same cycle.
REQ-034 Held id=7'b0_000101, flush_id=7'b0_000011, flush_valid=1, out_ready=1 -> out_valid=0 that cycle, no fire, held cleared next cycle; no req_ready during flush.
REQ-035 Held id=7'b1_000001, flush_id=7'b0_111110 (wrap) -> younger, killed; held id equal to flush_id -> retained and fires.
REQ-036 Preload grant_cnt0=16'hFFFE, two req0 fires -> 16'hFFFF and stays.
REQ-037 reset_n=0 for one cycle while held_valid=1 and both requesters valid -> all outputs per REQ-029, rr_ptr=0 so req0 wins the next tie.
